uart_alu_pkt_parser: RTL and testbench

UART_ALU_PKT_PARSER -- requirements
Module: uart_alu_pkt_parser

---
 rtl/uart_alu_pkt_parser.sv | 154 +++++++++++++++
 tb/tb_uart_alu_pkt_parser.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_pkt_parser.sv
// UART ALU packet parser: splits an opcode/reserved/length header from the payload stream.
// Optional inter-byte timeout is compiled in with `define PKT_PARSER_TIMEOUT_EN.
module uart_alu_pkt_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  s_axis_tdata_i,
  input  logic        s_axis_tvalid_i,
  output logic        s_axis_tready_o,
  output logic [7:0]  m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic        m_axis_tlast_o,
  output logic [7:0]  opcode_o,
  output logic [15:0] payload_len_o,
  output logic        hdr_valid_o,
  output logic        err_o
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned HDR_BYTES = 4;

  typedef enum logic [2:0] {
    S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_DROP
  } state_t;

  state_t             state_q;
  logic [BYTE_W-1:0]  op_q;
  logic [BYTE_W-1:0]  len_lo_q;
  logic [LEN_W-1:0]   rem_q;
  logic [BYTE_W-1:0]  m_tdata_q;
  logic               m_tvalid_q;
  logic               m_tlast_q;
  logic [BYTE_W-1:0]  opcode_q;
  logic [LEN_W-1:0]   payload_len_q;
  logic               hdr_valid_q;
  logic               err_q;

  logic               s_ready;
  logic               s_accept;
  logic               m_fire;
  logic               op_ok;
  logic [LEN_W-1:0]   len_full;
  logic [LEN_W-1:0]   len_body;
  logic               to_fire;

  // Header/drop states always take bytes; payload only when the output slot frees up.
  assign s_ready  = (state_q == S_PAYLOAD) ? (!m_tvalid_q || m_axis_tready_i) : 1'b1;
  assign s_accept = s_axis_tvalid_i && s_ready;
  assign m_fire   = m_tvalid_q && m_axis_tready_i;
  assign op_ok    = (op_q == 8'hEC) || (op_q == 8'hAD) || (op_q == 8'h88) || (op_q == 8'hD0);
  assign len_full = {s_axis_tdata_i, len_lo_q};
  assign len_body = len_full - LEN_W'(HDR_BYTES);

`ifdef PKT_PARSER_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        to_idle;

  // Idle = waiting for input mid-packet while not held off by a downstream stall.
  assign to_idle = (state_q != S_OPCODE) && !s_accept &&
                   !((state_q == S_PAYLOAD) && m_tvalid_q && !m_axis_tready_i);
  assign to_fire = to_idle && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || to_fire || !to_idle) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign to_fire        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_OPCODE;
      op_q          <= '0;
      len_lo_q      <= '0;
      rem_q         <= '0;
      m_tdata_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      opcode_q      <= '0;
      payload_len_q <= '0;
      hdr_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (m_fire) m_tvalid_q <= 1'b0;
      if (to_fire) begin
        err_q      <= 1'b1;
        m_tvalid_q <= 1'b0;
        rem_q      <= '0;
        state_q    <= S_OPCODE;
      end else if (s_accept) begin
        unique case (state_q)
          S_OPCODE: begin
            op_q    <= s_axis_tdata_i;
            state_q <= S_RSVD;
          end
          S_RSVD: state_q <= S_LEN_LO;
          S_LEN_LO: begin
            len_lo_q <= s_axis_tdata_i;
            state_q  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if (len_full < LEN_W'(HDR_BYTES)) begin
              err_q   <= 1'b1;
              state_q <= S_OPCODE;
            end else begin
              rem_q   <= len_body;
              state_q <= (len_body == '0) ? S_OPCODE : (op_ok ? S_PAYLOAD : S_DROP);
              if (op_ok) begin
                hdr_valid_q   <= 1'b1;
                opcode_q      <= op_q;
                payload_len_q <= len_body;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_PAYLOAD: begin
            m_tdata_q  <= s_axis_tdata_i;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= (rem_q == LEN_W'(1));
            rem_q      <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= S_OPCODE;
          end
          S_DROP: begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= S_OPCODE;
          end
          default: state_q <= S_OPCODE;
        endcase
      end
    end
  end

  assign s_axis_tready_o = s_ready;
  assign m_axis_tdata_o  = m_tdata_q;
  assign m_axis_tvalid_o = m_tvalid_q;
  assign m_axis_tlast_o  = m_tlast_q;
  assign opcode_o        = opcode_q;
  assign payload_len_o   = payload_len_q;
  assign hdr_valid_o     = hdr_valid_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_uart_alu_pkt_parser.sv
// Testbench for uart_alu_pkt_parser: table vectors, corner sequences and a random packet stream.
// The timeout scenario runs only when PKT_PARSER_TIMEOUT_EN is defined.
module tb_uart_alu_pkt_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic [7:0]  opcode;
  logic [15:0] plen;
  logic        hdr_valid;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;
  int rmode   = 0;   // 0: always ready, 1: toggle, 2: random

  logic [8:0]  act_beats[$];
  logic [8:0]  exp_beats[$];
  logic [23:0] act_hdr[$];
  logic [23:0] exp_hdr[$];
  int          act_err = 0;
  int          exp_err = 0;
  logic [7:0]  hold_op  = '0;
  logic [15:0] hold_len = '0;

  uart_alu_pkt_parser #(.TIMEOUT_CYCLES(50)) dut (
    .clk_i(clk), .reset_i(reset),
    .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready),
    .m_axis_tdata_o(m_data), .m_axis_tvalid_o(m_valid), .m_axis_tready_i(m_ready),
    .m_axis_tlast_o(m_last), .opcode_o(opcode), .payload_len_o(plen),
    .hdr_valid_o(hdr_valid), .err_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Output monitor: records beats/pulses and checks data holds steady under stall.
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat  = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !err) check("stall_hold", {23'd0, m_valid, m_last, m_data}, {23'd0, 1'b1, prev_beat});
      if (m_valid && m_ready) act_beats.push_back({m_last, m_data});
      if (hdr_valid) act_hdr.push_back({opcode, plen});
      if (err) act_err++;
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    act_beats.delete(); exp_beats.delete();
    act_hdr.delete();   exp_hdr.delete();
    act_err = 0; exp_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int   guard;
    guard   = 0;
    s_data  = b;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
      if (ok) break;
      guard++;
      if (guard > 1000) begin
        n_total++;
        $display("FAIL send_byte: byte 0x%0h not accepted within 1000 cycles", b);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [15:0] len, input logic [7:0] pl[$]);
    send_byte(op);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (pl[k]) send_byte(pl[k]);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (m_valid && g < 200) begin cyc(1); g++; end
    if (g >= 200) begin
      n_total++;
      $display("FAIL drain: m_axis_tvalid_o still high after 200 cycles");
    end
    cyc(3);
  endtask

  // Reference model: what the spec says a whole packet should produce.
  task automatic model_pkt(input logic [7:0] op, input logic [15:0] len, input logic [7:0] pl[$]);
    if (len < 16'd4) begin
      exp_err++;
    end else if (op == 8'hEC || op == 8'hAD || op == 8'h88 || op == 8'hD0) begin
      exp_hdr.push_back({op, len - 16'd4});
      foreach (pl[k]) exp_beats.push_back({(k == pl.size() - 1), pl[k]});
      hold_op  = op;
      hold_len = len - 16'd4;
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready),   32'd1);
    check({tag, "_m_valid"}, 32'(m_valid),   32'd0);
    check({tag, "_m_last"},  32'(m_last),    32'd0);
    check({tag, "_m_data"},  32'(m_data),    32'd0);
    check({tag, "_opcode"},  32'(opcode),    32'd0);
    check({tag, "_plen"},    32'(plen),      32'd0);
    check({tag, "_hdr"},     32'(hdr_valid), 32'd0);
    check({tag, "_err"},     32'(err),       32'd0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] len;
    int          exp_hdr;
    int          exp_err;
    int          exp_plen;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] pl[$];
    int nbytes;
    nbytes = (v.len >= 16'd4) ? int'(v.len) - 4 : 0;
    for (int k = 0; k < nbytes; k++) pl.push_back(8'((k + 1) * 17));
    clear_q();
    send_pkt(v.op, v.len, pl);
    drain();
    check({tag, "_hdr_cnt"}, 32'(act_hdr.size()), 32'(v.exp_hdr));
    check({tag, "_err_cnt"}, 32'(act_err), 32'(v.exp_err));
    if (v.exp_hdr != 0 && act_hdr.size() > 0)
      check({tag, "_hdr_val"}, 32'(act_hdr[0]), {8'd0, v.op, 16'(v.exp_plen)});
    check({tag, "_beat_cnt"}, 32'(act_beats.size()), 32'(v.exp_plen));
    for (int k = 0; k < act_beats.size() && k < v.exp_plen; k++)
      check({tag, "_beat"}, 32'(act_beats[k]), {23'd0, (k == v.exp_plen - 1), 8'((k + 1) * 17)});
    if (v.exp_hdr != 0) begin
      hold_op  = v.op;
      hold_len = 16'(v.exp_plen);
    end
    check({tag, "_opcode_hold"}, 32'(opcode), 32'(hold_op));
    check({tag, "_plen_hold"},   32'(plen),   32'(hold_len));
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_hdr_cnt"},  32'(act_hdr.size()),   32'(exp_hdr.size()));
    check({tag, "_err_cnt"},  32'(act_err),          32'(exp_err));
    check({tag, "_beat_cnt"}, 32'(act_beats.size()), 32'(exp_beats.size()));
    for (int k = 0; k < act_hdr.size() && k < exp_hdr.size(); k++)
      check({tag, "_hdr"}, 32'(act_hdr[k]), 32'(exp_hdr[k]));
    for (int k = 0; k < act_beats.size() && k < exp_beats.size(); k++)
      check({tag, "_beat"}, 32'(act_beats[k]), 32'(exp_beats[k]));
    check({tag, "_opcode_hold"}, 32'(opcode), 32'(hold_op));
    check({tag, "_plen_hold"},   32'(plen),   32'(hold_len));
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] op;
    logic [15:0] len;
    int r;

    vecs[0] = '{8'hEC, 16'h0008, 1, 0, 4};
    vecs[1] = '{8'h55, 16'h0006, 0, 1, 0};
    vecs[2] = '{8'hEC, 16'h0004, 1, 0, 0};
    vecs[3] = '{8'hAD, 16'h0003, 0, 1, 0};
    vecs[4] = '{8'hAD, 16'h000C, 1, 0, 8};
    vecs[5] = '{8'h88, 16'h0005, 1, 0, 1};
    vecs[6] = '{8'hD0, 16'h0108, 1, 0, 260};
    vecs[7] = '{8'h00, 16'h0004, 0, 1, 0};
    vecs[8] = '{8'hD0, 16'h0000, 0, 1, 0};
    vecs[9] = '{8'hFF, 16'h0009, 0, 1, 0};

    reset = 1'b1; s_valid = 1'b0; s_data = '0;
    cyc(3);
    check_reset_vals("por");
    reset = 1'b0;
    cyc(2);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Same echo packet under a toggling downstream ready.
    rmode = 1;
    run_vec(vecs[0], "toggle");
    rmode = 0;
    cyc(2);

    // Reset lands after two payload bytes of an in-flight packet.
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22);
    send_pkt(8'hEC, 16'h0008, pl);
    reset = 1'b1;
    cyc(2);
    check_reset_vals("midrst");
    reset = 1'b0;
    hold_op = '0; hold_len = '0;
    cyc(1);
    run_vec(vecs[0], "postrst");

    // Random back-to-back packet stream against the reference model.
    rmode = 2;
    clear_q();
    for (int p = 0; p < 30; p++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    op = 8'hEC;
        2, 3:    op = 8'hAD;
        4, 5:    op = 8'h88;
        6, 7:    op = 8'hD0;
        default: op = 8'($urandom);
      endcase
      len = 16'($urandom_range(0, 24));
      pl.delete();
      if (len >= 16'd4) for (int k = 4; k < int'(len); k++) pl.push_back(8'($urandom));
      model_pkt(op, len, pl);
      send_pkt(op, len, pl);
    end
    drain();
    compare_model("rand");
    rmode = 0;
    cyc(2);

`ifdef PKT_PARSER_TIMEOUT_EN
    clear_q();
    send_byte(8'hEC);
    send_byte(8'h00);
    cyc(48);
    check("to_early", 32'(act_err), 32'd0);
    cyc(7);
    check("to_err", 32'(act_err), 32'd1);
    check("to_no_hdr", 32'(act_hdr.size()), 32'd0);
    clear_q();
    pl.delete(); pl.push_back(8'h7F);
    model_pkt(8'hEC, 16'h0005, pl);
    send_pkt(8'hEC, 16'h0005, pl);
    drain();
    compare_model("to_next");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
